window_fetch: RTL
=================

WINDOW_FETCH -- requirements
Module: window_fetch

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- KERNEL_SIZE, 3, kernel edge length; taps per window = KERNEL_SIZE*KERNEL_SIZE.
- DATA_WIDTH, 8, pixel and kernel word width.
- SRAM_ADDR_WIDTH, 4, image SRAM and kernel SRAM address width.
- IMG_WIDTH, 4, image row pitch in words.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- i_clk, in, 1, single clock; all logic on its rising edge.
- i_rst, in, 1, synchronous, active-high reset.
- i_start, in, 1, request to fetch one window pair.
- i_org_row, in, SRAM_ADDR_WIDTH, window origin row.
- i_org_col, in, SRAM_ADDR_WIDTH, window origin column.
- o_rd_en, out, 1, SRAM read enable.
- o_win1_raddr, out, SRAM_ADDR_WIDTH, image SRAM port-1 read address.
- o_win2_raddr, out, SRAM_ADDR_WIDTH, image SRAM port-2 read address.
- o_kernel_raddr, out, SRAM_ADDR_WIDTH, kernel SRAM read address.
- i_win1_rdata, in, DATA_WIDTH, port-1 read data, valid the cycle after o_rd_en.
- i_win2_rdata, in, DATA_WIDTH, port-2 read data, same timing.
- i_kernel_rdata, in, DATA_WIDTH, kernel read data, same timing.
- o_conv_start, out, 1, downstream convolve strobe; tap data valid.
- o_window1_addr, out, SRAM_ADDR_WIDTH, address of the presented window-1 tap.
- o_window1_data, out, DATA_WIDTH, window-1 tap data.
- o_window2_addr, out, SRAM_ADDR_WIDTH, address of the presented window-2 tap.
- o_window2_data, out, DATA_WIDTH, window-2 tap data.
- o_kernel_data, out, DATA_WIDTH, kernel tap data.
- o_busy, out, 1, operation in progress.
- o_done, out, 1, one-cycle completion pulse.

Function
REQ-003 FSM states SHALL be IDLE, FETCH, DRAIN, DONE, with o_busy = (state != IDLE).
REQ-004 i_start SHALL be sampled only in IDLE; when sampled, the block SHALL register i_org_row and i_org_col, clear r and c, and enter FETCH. In all other states i_start SHALL be ignored.
REQ-005 FETCH SHALL issue one read per cycle for taps k = r*KERNEL_SIZE + c, k = 0..KERNEL_SIZE^2-1. c SHALL increment first; it SHALL wrap to 0 at KERNEL_SIZE-1 and r SHALL then increment.
REQ-006 All read-side outputs SHALL be registered. For tap k: o_win1_raddr = ((org_row+r)*IMG_WIDTH + org_col + c) mod 2^SRAM_ADDR_WIDTH. o_win2_raddr = (o_win1_raddr+1) mod 2^SRAM_ADDR_WIDTH. o_kernel_raddr = k.
REQ-007 Wrap beyond 2^SRAM_ADDR_WIDTH SHALL be silent truncation, with no error flag.
REQ-008 After the last tap is issued, FETCH SHALL go to DRAIN for exactly one cycle, then to DONE for exactly one cycle, then to IDLE.
REQ-009 o_conv_start SHALL be o_rd_en delayed one cycle. o_window1_addr and o_window2_addr SHALL be the read addresses delayed one cycle.
REQ-010 o_window1_data, o_window2_data and o_kernel_data SHALL be combinational pass-throughs of i_win1_rdata, i_win2_rdata and i_kernel_rdata.
REQ-011 Timing, with i_start sampled in cycle 0:
- o_rd_en high in cycles 1..KERNEL_SIZE^2, carrying tap k in cycle k+1.
- o_conv_start high in cycles 2..KERNEL_SIZE^2+1.
- o_done high only in cycle KERNEL_SIZE^2+2.
- IDLE re-entered in cycle KERNEL_SIZE^2+3.
REQ-012 When no read is issued, o_rd_en SHALL be 0, and o_win1_raddr, o_win2_raddr and o_kernel_raddr SHALL hold their last values.

Reset
REQ-013 On i_rst=1 at a rising edge, the state SHALL become IDLE and r, c, the latched origin and all registered outputs SHALL become 0, regardless of state.
REQ-014 Reset asserted mid-operation SHALL abort the operation with no o_done pulse and no further o_conv_start.
REQ-015 i_start sampled in the same cycle as i_rst SHALL be ignored.

Verification
REQ-016 With defaults and origin (0,0), start in cycle 0:
- o_win1_raddr SHALL be 0,1,2,4,5,6,8,9,10 and o_win2_raddr 1,2,3,5,6,7,9,10,11 in cycles 1..9.
- o_kernel_raddr SHALL be 0..8.
- o_conv_start SHALL be high in cycles 2..10, o_done in cycle 11, o_busy in cycles 1..11.
REQ-017 With origin (1,1), o_win1_raddr SHALL be 5,6,7,9,10,11,13,14,15 and o_win2_raddr 6,7,8,10,11,12,14,15,0, which checks the wrap at 16 to 0.
REQ-018 With an SRAM model returning data = address and kernel data = 10+k, each o_conv_start cycle SHALL present o_window1_data = o_window1_addr, o_window2_data = o_window2_addr and o_kernel_data = 10+k.
REQ-019 Busy-start and restart:
- An i_start pulse in cycle 5 with origin (2,2) SHALL be ignored, so the sequence stays (0,0).
- An i_start in cycle 11 (DONE) SHALL be ignored.
- An i_start in cycle 12 SHALL produce o_rd_en in cycle 13.
REQ-020 i_rst high in cycle 5 SHALL produce, from cycle 6: all outputs 0, o_busy=0, and no o_done in cycle 11. An i_start in cycle 7 SHALL then run a full, correct sequence.

Source files
------------

// File: rtl/window_fetch.sv
// Window fetch sequencer: walks a KERNEL_SIZE x KERNEL_SIZE window, issuing one image-pair and
// kernel SRAM read per cycle, then presents the returned taps with a convolve strobe.
module window_fetch #(
   parameter int KERNEL_SIZE     = 3,
   parameter int DATA_WIDTH      = 8,
   parameter int SRAM_ADDR_WIDTH = 4,
   parameter int IMG_WIDTH       = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_start,
   input  logic [SRAM_ADDR_WIDTH-1:0] i_org_row,
   input  logic [SRAM_ADDR_WIDTH-1:0] i_org_col,
   output logic                       o_rd_en,
   output logic [SRAM_ADDR_WIDTH-1:0] o_win1_raddr,
   output logic [SRAM_ADDR_WIDTH-1:0] o_win2_raddr,
   output logic [SRAM_ADDR_WIDTH-1:0] o_kernel_raddr,
   input  logic [DATA_WIDTH-1:0]      i_win1_rdata,
   input  logic [DATA_WIDTH-1:0]      i_win2_rdata,
   input  logic [DATA_WIDTH-1:0]      i_kernel_rdata,
   output logic                       o_conv_start,
   output logic [SRAM_ADDR_WIDTH-1:0] o_window1_addr,
   output logic [DATA_WIDTH-1:0]      o_window1_data,
   output logic [SRAM_ADDR_WIDTH-1:0] o_window2_addr,
   output logic [DATA_WIDTH-1:0]      o_window2_data,
   output logic [DATA_WIDTH-1:0]      o_kernel_data,
   output logic                       o_busy,
   output logic                       o_done
);

   localparam int AW = SRAM_ADDR_WIDTH;
   localparam int CW = $clog2(KERNEL_SIZE + 1);
   localparam logic [CW-1:0] KLast = CW'(KERNEL_SIZE - 1);
   localparam logic [CW-1:0] KEnd  = CW'(KERNEL_SIZE);

   typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

   state_e state_q, state_d;

   logic [CW-1:0] r_q, r_d, c_q, c_d;
   logic [AW-1:0] org_row_q, org_row_d, org_col_q, org_col_d;
   logic          rd_en_q, rd_en_d;
   logic [AW-1:0] win1_raddr_q, win1_raddr_d, win2_raddr_q, win2_raddr_d;
   logic [AW-1:0] kernel_raddr_q, kernel_raddr_d;
   logic          conv_start_q, conv_start_d;
   logic [AW-1:0] window1_addr_q, window1_addr_d, window2_addr_q, window2_addr_d;

   logic          start_ok, issue;
   logic [AW-1:0] row_base, col_base, win1_a;
   logic [CW-1:0] rr, cc;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= StIdle;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (i_start) state_d = StFetch;
         StFetch: if (r_q == KEnd) state_d = StDrain;
         StDrain: state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath next-state. Tap 0 is issued on the start edge straight from the origin inputs, so
   // r/c then hold the next tap to issue; r reaching KERNEL_SIZE marks the window exhausted.
   always_comb begin
      start_ok = (state_q == StIdle) && i_start;
      issue    = start_ok || ((state_q == StFetch) && (r_q != KEnd));
      row_base = start_ok ? i_org_row : org_row_q;
      col_base = start_ok ? i_org_col : org_col_q;
      rr       = start_ok ? '0 : r_q;
      cc       = start_ok ? '0 : c_q;
      win1_a   = AW'((32'(row_base) + 32'(rr)) * 32'(IMG_WIDTH) + 32'(col_base) + 32'(cc));

      org_row_d      = start_ok ? i_org_row : org_row_q;
      org_col_d      = start_ok ? i_org_col : org_col_q;
      r_d            = r_q;
      c_d            = c_q;
      rd_en_d        = 1'b0;
      win1_raddr_d   = win1_raddr_q;
      win2_raddr_d   = win2_raddr_q;
      kernel_raddr_d = kernel_raddr_q;

      if (issue) begin
         rd_en_d        = 1'b1;
         win1_raddr_d   = win1_a;
         win2_raddr_d   = win1_a + AW'(1);
         kernel_raddr_d = AW'(32'(rr) * 32'(KERNEL_SIZE) + 32'(cc));
         if (cc == KLast) begin
            c_d = '0;
            r_d = rr + CW'(1);
         end else begin
            c_d = cc + CW'(1);
            r_d = rr;
         end
      end

      conv_start_d   = rd_en_q;
      window1_addr_d = win1_raddr_q;
      window2_addr_d = win2_raddr_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q            <= '0;
         c_q            <= '0;
         org_row_q      <= '0;
         org_col_q      <= '0;
         rd_en_q        <= 1'b0;
         win1_raddr_q   <= '0;
         win2_raddr_q   <= '0;
         kernel_raddr_q <= '0;
         conv_start_q   <= 1'b0;
         window1_addr_q <= '0;
         window2_addr_q <= '0;
      end else begin
         r_q            <= r_d;
         c_q            <= c_d;
         org_row_q      <= org_row_d;
         org_col_q      <= org_col_d;
         rd_en_q        <= rd_en_d;
         win1_raddr_q   <= win1_raddr_d;
         win2_raddr_q   <= win2_raddr_d;
         kernel_raddr_q <= kernel_raddr_d;
         conv_start_q   <= conv_start_d;
         window1_addr_q <= window1_addr_d;
         window2_addr_q <= window2_addr_d;
      end
   end

   // Output logic
   always_comb begin
      o_busy         = (state_q != StIdle);
      o_done         = (state_q == StDone);
      o_rd_en        = rd_en_q;
      o_win1_raddr   = win1_raddr_q;
      o_win2_raddr   = win2_raddr_q;
      o_kernel_raddr = kernel_raddr_q;
      o_conv_start   = conv_start_q;
      o_window1_addr = window1_addr_q;
      o_window2_addr = window2_addr_q;
      o_window1_data = i_win1_rdata;
      o_window2_data = i_win2_rdata;
      o_kernel_data  = i_kernel_rdata;
   end

endmodule
